// File: rtl/axi_chan_hs_checker.sv
// Passive VALID/READY handshake checker for a single AXI channel.
// Tracks channel state, counts handshakes and flags protocol violations.
// Never drives the bus; every output is registered (one cycle latency).
//
// state | meaning
// RESET | reset asserted, or the first edge after release
// IDLE  | no beat pending
// WAIT  | VALID high, READY low; payload captured on entry
// HS    | handshake sampled on the previous edge
module axi_chan_hs_checker #(
  parameter int DATA_W  = 45,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] payload,
  input  logic              err_clr,
  output logic [1:0]        state_o,
  output logic              hs_pulse,
  output logic [CNT_W-1:0]  hs_count,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              err_drop,
  output logic              err_stable,
  output logic              err_tmo,
  output logic              err_rst,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HS    = 2'd3;

  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
  localparam logic             TMO_EN  = (TIMEOUT > 0);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_cap;
  logic [CNT_W-1:0]  r_stall;
  logic [CNT_W-1:0]  r_hs_count;
  logic [CNT_W-1:0]  r_err_count;
  logic              r_hs_pulse;
  logic              r_err_drop;
  logic              r_err_stable;
  logic              r_err_tmo;
  logic              r_err_rst;
  logic              r_err_sticky;

  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] w_cap_nxt;
  logic [CNT_W-1:0]  w_stall_nxt;
  logic              w_hs;
  logic              w_e_drop;
  logic              w_e_stable;
  logic              w_e_tmo;
  logic              w_e_rst;
  logic [2:0]        w_npulse;
  logic [CNT_W-1:0]  w_err_base;
  logic [CNT_W:0]    w_err_sum;
  logic [CNT_W-1:0]  w_err_cnt_nxt;
  logic [CNT_W-1:0]  w_hs_cnt_nxt;
  logic              w_sticky_nxt;

  // Next-state, capture and stall counter, plus raw drop/stable/reset errors
  always_comb begin
    w_state_nxt = r_state;
    w_cap_nxt   = r_cap;
    w_stall_nxt = r_stall;
    w_hs        = 1'b0;
    w_e_drop    = 1'b0;
    w_e_stable  = 1'b0;
    w_e_rst     = 1'b0;
    case (r_state)
      ST_RESET: begin
        // A handshake on the release edge is flagged, not counted
        w_state_nxt = ST_IDLE;
        w_e_rst     = valid;
        w_stall_nxt = '0;
      end
      ST_WAIT: begin
        w_e_stable = valid && (payload != r_cap);
        if (valid && ready) begin
          w_state_nxt = ST_HS;
          w_hs        = 1'b1;
          w_stall_nxt = '0;
        end else if (valid) begin
          w_stall_nxt = (&r_stall) ? r_stall : r_stall + ONE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_e_drop    = 1'b1;
          w_stall_nxt = '0;
        end
      end
      default: begin
        if (valid && ready) begin
          w_state_nxt = ST_HS;
          w_hs        = 1'b1;
          w_stall_nxt = '0;
        end else if (valid) begin
          w_state_nxt = ST_WAIT;
          w_cap_nxt   = payload;
          w_stall_nxt = ONE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_stall_nxt = '0;
        end
      end
    endcase
  end

  // Timeout fires only on the edge the stall count arrives at TIMEOUT, so a
  // count parked at saturation cannot re-trigger it
  always_comb begin
    w_e_tmo = TMO_EN && (w_stall_nxt == TMO_VAL) && (r_stall != TMO_VAL);
  end

  // Error and handshake counter arithmetic; err_clr restarts from zero but
  // still accounts for errors raised on the same edge
  always_comb begin
    w_npulse      = {2'b00, w_e_drop} + {2'b00, w_e_stable}
                  + {2'b00, w_e_tmo} + {2'b00, w_e_rst};
    w_err_base    = err_clr ? '0 : r_err_count;
    w_err_sum     = {1'b0, w_err_base} + {{(CNT_W-2){1'b0}}, w_npulse};
    w_err_cnt_nxt = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    w_sticky_nxt  = (err_clr ? 1'b0 : r_err_sticky)
                  | w_e_drop | w_e_stable | w_e_tmo | w_e_rst;
    w_hs_cnt_nxt  = (w_hs && !(&r_hs_count)) ? r_hs_count + ONE : r_hs_count;
  end

  // State and output registers; reset drops any open beat silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RESET;
      r_cap        <= '0;
      r_stall      <= '0;
      r_hs_count   <= '0;
      r_err_count  <= '0;
      r_hs_pulse   <= 1'b0;
      r_err_drop   <= 1'b0;
      r_err_stable <= 1'b0;
      r_err_tmo    <= 1'b0;
      r_err_rst    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cap        <= w_cap_nxt;
      r_stall      <= w_stall_nxt;
      r_hs_count   <= w_hs_cnt_nxt;
      r_err_count  <= w_err_cnt_nxt;
      r_hs_pulse   <= w_hs;
      r_err_drop   <= w_e_drop;
      r_err_stable <= w_e_stable;
      r_err_tmo    <= w_e_tmo;
      r_err_rst    <= w_e_rst;
      r_err_sticky <= w_sticky_nxt;
    end
  end

  assign state_o    = r_state;
  assign hs_pulse   = r_hs_pulse;
  assign hs_count   = r_hs_count;
  assign stall_cnt  = r_stall;
  assign err_drop   = r_err_drop;
  assign err_stable = r_err_stable;
  assign err_tmo    = r_err_tmo;
  assign err_rst    = r_err_rst;
  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_axi_chan_hs_checker.sv
// Directed bench for axi_chan_hs_checker (DATA_W=45, TIMEOUT=16, CNT_W=16).
module tb_axi_chan_hs_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  logic [44:0] payload = '0;
  logic        err_clr = 1'b0;
  logic [1:0]  state_o;
  logic        hs_pulse;
  logic [15:0] hs_count;
  logic [15:0] stall_cnt;
  logic        err_drop;
  logic        err_stable;
  logic        err_tmo;
  logic        err_rst;
  logic        err_sticky;
  logic [15:0] err_count;

  int total = 0;
  int bad = 0;

  axi_chan_hs_checker #(.DATA_W(45), .TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .payload(payload),
    .err_clr(err_clr), .state_o(state_o), .hs_pulse(hs_pulse), .hs_count(hs_count),
    .stall_cnt(stall_cnt), .err_drop(err_drop), .err_stable(err_stable),
    .err_tmo(err_tmo), .err_rst(err_rst), .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    tick();
    tick();
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if ({hs_pulse, hs_count, stall_cnt, err_count} !== 49'd0) begin bad++; $display("FAIL reset_counts got=%0h exp=0", {hs_pulse, hs_count, stall_cnt, err_count}); end
    total++; if ({err_drop, err_stable, err_tmo, err_rst, err_sticky} !== 5'd0) begin bad++; $display("FAIL reset_errs got=%b exp=00000", {err_drop, err_stable, err_tmo, err_rst, err_sticky}); end
  endtask

  task automatic test_handshake();
    reset = 1'b0;
    tick();
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL release_idle got=%0d exp=1", state_o); end
    total++; if (err_rst !== 1'b0) begin bad++; $display("FAIL release_no_err_rst got=%b exp=0", err_rst); end
    valid = 1'b1; ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (state_o !== 2'd3) begin bad++; $display("FAIL b2b_state beat=%0d got=%0d exp=3", i, state_o); end
      total++; if (hs_pulse !== 1'b1) begin bad++; $display("FAIL b2b_pulse beat=%0d got=%b exp=1", i, hs_pulse); end
      total++; if (hs_count !== 16'(i)) begin bad++; $display("FAIL b2b_count beat=%0d got=%0d exp=%0d", i, hs_count, i); end
    end
    valid = 1'b0; ready = 1'b0;
    tick();
    total++; if ({state_o, hs_pulse, hs_count} !== {2'd1, 1'b0, 16'd3}) begin bad++; $display("FAIL hs_idle got=%0d/%b/%0d exp=1/0/3", state_o, hs_pulse, hs_count); end
    total++; if ({err_sticky, err_count} !== 17'd0) begin bad++; $display("FAIL hs_no_err got=%b/%0d exp=0/0", err_sticky, err_count); end
  endtask

  task automatic test_stall();
    payload = 45'h1234; valid = 1'b1; ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (state_o !== 2'd2) begin bad++; $display("FAIL stall_state cyc=%0d got=%0d exp=2", i, state_o); end
      total++; if (stall_cnt !== 16'(i)) begin bad++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, i); end
    end
    ready = 1'b1;
    tick();
    total++; if ({state_o, hs_pulse, hs_count, stall_cnt} !== {2'd3, 1'b1, 16'd4, 16'd0}) begin bad++; $display("FAIL stall_hs got=%0d/%b/%0d/%0d exp=3/1/4/0", state_o, hs_pulse, hs_count, stall_cnt); end
    total++; if ({err_stable, err_sticky, err_count} !== 18'd0) begin bad++; $display("FAIL stall_no_err got=%b/%b/%0d exp=0/0/0", err_stable, err_sticky, err_count); end
    valid = 1'b0; ready = 1'b0;
    tick();
  endtask

  task automatic test_stable();
    payload = 45'h1234; valid = 1'b1; ready = 1'b0;
    tick();
    total++; if (err_stable !== 1'b0) begin bad++; $display("FAIL stable_entry got=%b exp=0", err_stable); end
    payload = 45'h1235;
    tick();
    total++; if ({err_stable, err_sticky, err_count} !== {1'b1, 1'b1, 16'd1}) begin bad++; $display("FAIL stable_pulse got=%b/%b/%0d exp=1/1/1", err_stable, err_sticky, err_count); end
    payload = 45'h1234;
    tick();
    total++; if ({err_stable, err_sticky, err_count} !== {1'b0, 1'b1, 16'd1}) begin bad++; $display("FAIL stable_once got=%b/%b/%0d exp=0/1/1", err_stable, err_sticky, err_count); end
    ready = 1'b1;
    tick();
    total++; if ({state_o, hs_count, err_stable} !== {2'd3, 16'd5, 1'b0}) begin bad++; $display("FAIL stable_hs got=%0d/%0d/%b exp=3/5/0", state_o, hs_count, err_stable); end
    valid = 1'b0; ready = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    valid = 1'b1; ready = 1'b0;
    tick();
    tick();
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL drop_stall got=%0d exp=2", stall_cnt); end
    valid = 1'b0;
    tick();
    total++; if ({err_drop, state_o, stall_cnt} !== {1'b1, 2'd1, 16'd0}) begin bad++; $display("FAIL drop_pulse got=%b/%0d/%0d exp=1/1/0", err_drop, state_o, stall_cnt); end
    total++; if ({hs_count, err_count} !== {16'd5, 16'd2}) begin bad++; $display("FAIL drop_counts got=%0d/%0d exp=5/2", hs_count, err_count); end
    tick();
    total++; if (err_drop !== 1'b0) begin bad++; $display("FAIL drop_width got=%b exp=0", err_drop); end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    valid = 1'b1; ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (err_tmo === 1'b1) pulses++;
      total++; if (err_tmo !== (i == 16)) begin bad++; $display("FAIL tmo_pulse cyc=%0d got=%b exp=%b", i, err_tmo, (i == 16)); end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL tmo_count got=%0d exp=1", pulses); end
    total++; if ({stall_cnt, err_count} !== {16'd20, 16'd3}) begin bad++; $display("FAIL tmo_end got=%0d/%0d exp=20/3", stall_cnt, err_count); end
    ready = 1'b1;
    tick();
    total++; if ({hs_count, stall_cnt} !== {16'd6, 16'd0}) begin bad++; $display("FAIL tmo_hs got=%0d/%0d exp=6/0", hs_count, stall_cnt); end
    valid = 1'b0; ready = 1'b0;
    tick();
  endtask

  task automatic test_err_clr();
    valid = 1'b1; ready = 1'b0;
    tick();
    valid = 1'b0; err_clr = 1'b1;
    tick();
    total++; if ({err_drop, err_sticky, err_count} !== {1'b1, 1'b1, 16'd1}) begin bad++; $display("FAIL clr_with_err got=%b/%b/%0d exp=1/1/1", err_drop, err_sticky, err_count); end
    tick();
    total++; if ({err_sticky, err_count} !== 17'd0) begin bad++; $display("FAIL clr_plain got=%b/%0d exp=0/0", err_sticky, err_count); end
    total++; if (hs_count !== 16'd6) begin bad++; $display("FAIL clr_keeps_hs got=%0d exp=6", hs_count); end
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    payload = 45'h55; valid = 1'b1; ready = 1'b0;
    tick();
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL mid_wait got=%0d exp=2", state_o); end
    #1 reset = 1'b1;
    #1;
    total++; if ({state_o, stall_cnt, hs_count, err_count} !== 50'd0) begin bad++; $display("FAIL mid_async got=%0h exp=0", {state_o, stall_cnt, hs_count, err_count}); end
    tick();
    total++; if ({err_drop, err_sticky, err_rst} !== 3'd0) begin bad++; $display("FAIL mid_no_drop got=%b exp=000", {err_drop, err_sticky, err_rst}); end
    ready = 1'b1;
    reset = 1'b0;
    tick();
    total++; if ({state_o, err_rst, err_sticky, err_count} !== {2'd1, 1'b1, 1'b1, 16'd1}) begin bad++; $display("FAIL rst_valid got=%0d/%b/%b/%0d exp=1/1/1/1", state_o, err_rst, err_sticky, err_count); end
    total++; if ({hs_pulse, hs_count} !== 17'd0) begin bad++; $display("FAIL rst_no_hs got=%b/%0d exp=0/0", hs_pulse, hs_count); end
    tick();
    total++; if ({state_o, hs_count, err_rst} !== {2'd3, 16'd1, 1'b0}) begin bad++; $display("FAIL post_rst_hs got=%0d/%0d/%b exp=3/1/0", state_o, hs_count, err_rst); end
    valid = 1'b0; ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_stall();
    test_stable();
    test_drop();
    test_timeout();
    test_err_clr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
